// File: rtl/pulse_burst_if.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_burst_if
//  Description : Trigger/abort strobes and burst status bundle for pulse_burst.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pulse_burst_if #(
    parameter int DROPW = 8
) ();
    logic             trig;
    logic             abort;
    logic             pulse;
    logic             busy;
    logic             done;
    logic [DROPW-1:0] dropped;

    modport master (
        output trig,
        output abort,
        input  pulse,
        input  busy,
        input  done,
        input  dropped
    );

    modport slave (
        input  trig,
        input  abort,
        output pulse,
        output busy,
        output done,
        output dropped
    );
endinterface
`default_nettype wire

// File: rtl/pulse_burst.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_burst
//  Description : Trigger-driven burst sequencer: delay, then COUNT pulses of
//                HIGH cycles separated by LOW cycles; busy/done/dropped status.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_burst #(
    parameter int DLY    = 2,
    parameter int HIGH   = 2,
    parameter int LOW    = 3,
    parameter int COUNT  = 4,
    parameter int RETRIG = 0,
    parameter int DROPW  = 8
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    pulse_burst_if.slave     bus
);

    localparam int C_MAX_A  = (DLY > HIGH) ? DLY : HIGH;
    localparam int C_MAX_B  = (LOW > COUNT) ? LOW : COUNT;
    localparam int C_MAX    = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
    localparam int C_CNT_W  = $clog2(C_MAX + 1) + 1;

    // Terminal counts are clamped at 0 so that unused phases (DLY=0, or LOW=0
    // with a single pulse) still elaborate to legal constants.
    localparam logic [C_CNT_W-1:0] C_DLY_LAST  = C_CNT_W'((DLY   > 0) ? DLY   - 1 : 0);
    localparam logic [C_CNT_W-1:0] C_HIGH_LAST = C_CNT_W'((HIGH  > 0) ? HIGH  - 1 : 0);
    localparam logic [C_CNT_W-1:0] C_LOW_LAST  = C_CNT_W'((LOW   > 0) ? LOW   - 1 : 0);
    localparam logic [C_CNT_W-1:0] C_PCNT_LAST = C_CNT_W'((COUNT > 0) ? COUNT - 1 : 0);

    if (DLY < 0) begin : g_err_dly
        $error("pulse_burst: DLY must be >= 0");
    end
    if (HIGH < 1) begin : g_err_high
        $error("pulse_burst: HIGH must be >= 1");
    end
    if (COUNT < 1) begin : g_err_count
        $error("pulse_burst: COUNT must be >= 1");
    end
    if ((LOW < 1) && (COUNT > 1)) begin : g_err_low
        $error("pulse_burst: LOW must be >= 1 when COUNT > 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HIGH = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [C_CNT_W-1:0] cnt_q,     cnt_d;
    logic [C_CNT_W-1:0] pcnt_q,    pcnt_d;
    logic [DROPW-1:0]   dropped_q, dropped_d;
    logic               pulse_q,   pulse_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               w_start;

    // A trigger opens a burst from idle, or restarts one when retriggering is on.
    assign w_start = bus.trig && !bus.abort && ((state_q == S_IDLE) || (RETRIG != 0));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pcnt_d    = pcnt_q;
        dropped_d = dropped_q;
        done_d    = 1'b0;

        if (bus.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
        end else if (w_start) begin
            state_d = (DLY > 0) ? S_WAIT : S_HIGH;
            cnt_d   = '0;
            pcnt_d  = '0;
        end else begin
            // Only reachable with a trigger while busy and retriggering off.
            if (bus.trig && (dropped_q != {DROPW{1'b1}})) begin
                dropped_d = dropped_q + 1'b1;
            end
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == C_DLY_LAST) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt_q == C_HIGH_LAST) begin
                        cnt_d = '0;
                        if (pcnt_q == C_PCNT_LAST) begin
                            state_d = S_IDLE;
                            pcnt_d  = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            pcnt_d  = pcnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == C_LOW_LAST) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        pulse_d = (state_d == S_HIGH);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            dropped_q <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            dropped_q <= dropped_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.pulse   = pulse_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.dropped = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_burst
//  Description : Three pulse_burst configurations driven by shared directed
//                and random trig/abort, checked against a timeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_burst;

    logic clk = 1'b0;
    logic rstn;
    logic trig;
    logic abort;

    always #5 clk = ~clk;

    pulse_burst_if #(.DROPW(8)) if0 ();
    pulse_burst_if #(.DROPW(8)) if1 ();
    pulse_burst_if #(.DROPW(2)) if2 ();

    assign if0.trig = trig;  assign if0.abort = abort;
    assign if1.trig = trig;  assign if1.abort = abort;
    assign if2.trig = trig;  assign if2.abort = abort;

    pulse_burst #(.DLY(2), .HIGH(2), .LOW(3), .COUNT(4), .RETRIG(0), .DROPW(8))
        dut0 (.clk(clk), .rstn(rstn), .bus(if0));
    pulse_burst #(.DLY(1), .HIGH(1), .LOW(2), .COUNT(3), .RETRIG(1), .DROPW(8))
        dut1 (.clk(clk), .rstn(rstn), .bus(if1));
    pulse_burst #(.DLY(0), .HIGH(1), .LOW(1), .COUNT(2), .RETRIG(0), .DROPW(2))
        dut2 (.clk(clk), .rstn(rstn), .bus(if2));

    logic [2:0]  obs_pulse, obs_busy, obs_done;
    logic [31:0] obs_drop [3];
    assign obs_pulse = {if2.pulse, if1.pulse, if0.pulse};
    assign obs_busy  = {if2.busy,  if1.busy,  if0.busy};
    assign obs_done  = {if2.done,  if1.done,  if0.done};
    assign obs_drop[0] = 32'(if0.dropped);
    assign obs_drop[1] = 32'(if1.dropped);
    assign obs_drop[2] = 32'(if2.dropped);

    // Configuration table mirrored from the instances above.
    int p_dly [3] = '{2, 1, 0};
    int p_hi  [3] = '{2, 1, 1};
    int p_lo  [3] = '{3, 2, 1};
    int p_cnt [3] = '{4, 3, 2};
    int p_ret [3] = '{0, 1, 0};
    int p_dmax[3] = '{255, 255, 3};

    // Model: a burst is a timeline anchored at its trigger edge e0.
    int tests = 0;
    int fails = 0;
    int n     = 0;
    bit active [3];
    int e0     [3];
    int drop   [3];

    function automatic int blen(int i);
        return p_cnt[i] * p_hi[i] + (p_cnt[i] - 1) * p_lo[i];
    endfunction

    function automatic bit m_busy(int i);
        int k = n - e0[i];
        return active[i] && (k >= 0) && (k < p_dly[i] + blen(i));
    endfunction

    function automatic bit m_pulse(int i);
        int k = n - e0[i];
        if (!m_busy(i) || (k < p_dly[i])) return 1'b0;
        return ((k - p_dly[i]) % (p_hi[i] + p_lo[i])) < p_hi[i];
    endfunction

    function automatic bit m_done(int i);
        return active[i] && ((n - e0[i]) == p_dly[i] + blen(i));
    endfunction

    task automatic model_edge(bit t, bit a);
        bit bp [3];
        for (int i = 0; i < 3; i++) bp[i] = m_busy(i);
        n = n + 1;
        for (int i = 0; i < 3; i++) begin
            if (a) begin
                active[i] = 1'b0;
            end else if (t && (!bp[i] || (p_ret[i] != 0))) begin
                active[i] = 1'b1;
                e0[i]     = n;
            end else if (t && (drop[i] < p_dmax[i])) begin
                drop[i] = drop[i] + 1;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(string ph);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s.d%0d.pulse@%0d", ph, i, n), 32'(obs_pulse[i]), 32'(m_pulse(i)));
            check($sformatf("%s.d%0d.busy@%0d",  ph, i, n), 32'(obs_busy[i]),  32'(m_busy(i)));
            check($sformatf("%s.d%0d.done@%0d",  ph, i, n), 32'(obs_done[i]),  32'(m_done(i)));
            check($sformatf("%s.d%0d.drop@%0d",  ph, i, n), obs_drop[i],       32'(drop[i]));
        end
    endtask

    task automatic step(string ph, bit t, bit a);
        @(negedge clk);
        trig  = t;
        abort = a;
        @(posedge clk);
        model_edge(t, a);
        #1;
        check_all(ph);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            active[i] = 1'b0;
            drop[i]   = 0;
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        trig  = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn  = 1'b0;
        trig  = 1'b0;
        abort = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Single burst, full length plus the done cycle and idle tail.
        repeat (3) step("idle", 1'b0, 1'b0);
        step("trig", 1'b1, 1'b0);
        repeat (25) step("burst", 1'b0, 1'b0);

        // Trigger while busy, then abort (with a trigger) mid-burst and in idle.
        step("trig2", 1'b1, 1'b0);
        repeat (4) step("burst2", 1'b0, 1'b0);
        step("busytrig", 1'b1, 1'b0);
        repeat (2) step("burst2", 1'b0, 1'b0);
        step("abort", 1'b1, 1'b1);
        step("abort_idle", 1'b1, 1'b1);
        repeat (3) step("idle2", 1'b0, 1'b0);

        // Trigger train: drop counting and saturation of the narrow counter.
        repeat (6) step("train", 1'b1, 1'b0);
        repeat (30) step("drain", 1'b0, 1'b0);

        for (int s = 0; s < 2000; s++) begin
            step("rand", ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0));
        end

        step("pre_rst", 1'b1, 1'b0);
        repeat (3) step("pre_rst", 1'b0, 1'b0);
        mid_reset();

        for (int s = 0; s < 500; s++) begin
            step("rand2", ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
